gpio_cfg_serializer: RTL and testbench

Upstream feeder for the padframe. Walks the per-pad configuration table, one CFG_BITS word per user GPIO pad, and shifts it into the daisy-chained pad control blocks. Those blocks drive the pad controls (mprj_io_oeb, mprj_io_dm, inp_dis, vtrip_sel, slow_sel, analog_*, holdover, ...). A final load strobe transfers the chain into the live pad-control registers.

---
 rtl/gpio_cfg_pkg.sv | 34 +++
 rtl/gpio_cfg_serializer.sv | 126 ++++++++++++
 tb/tb_gpio_cfg_serializer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad-configuration serializer: word layout,
// FSM state encoding and the power-up configuration word.
package gpio_cfg_pkg;

    localparam int CFG_BITS = 13;

    // Bit positions inside one pad configuration word.
    localparam int CFG_MGMT_ENA    = 0;
    localparam int CFG_OEB         = 1;
    localparam int CFG_HLDH        = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW_SEL    = 8;
    localparam int CFG_VTRIP_SEL   = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_MSB      = 12;

    // Management-owned, output disabled, dm = 3'b110.
    localparam logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h1803;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD_HI,
        ST_LOAD_LO
    } state_t;

endpackage

// File: rtl/gpio_cfg_serializer.sv
// Walks the pad configuration table from the highest pad down to pad 0 and
// shifts each word MSB-first into the pad control chain, then pulses load.
module gpio_cfg_serializer #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = gpio_cfg_pkg::CFG_BITS,
    parameter int CLK_DIV  = 2,
    parameter int IDX_W    = $clog2(NUM_PADS)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic [IDX_W-1:0]    cfg_rd_idx,
    input  logic [CFG_BITS-1:0] cfg_rd_data,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                serial_resetn
);
    import gpio_cfg_pkg::*;

    localparam int                BIT_W      = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam logic [7:0]        PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP    = BIT_W'(CFG_BITS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_phase;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [IDX_W-1:0]    r_pad_idx;
    logic [CFG_BITS-1:0] r_shift;
    logic [CFG_BITS-1:0] w_shift_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_sdo;
    logic                r_load;
    logic                r_sresetn;
    logic                w_phase_last;

    assign w_phase_last = (r_phase == PHASE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (xfer_start) w_state_nxt = ST_FETCH;
            ST_FETCH:    w_state_nxt = ST_LATCH;
            ST_LATCH:    w_state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_phase_last) w_state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: begin
                if (w_phase_last) begin
                    if (r_bit_cnt != '0)      w_state_nxt = ST_SHIFT_LO;
                    else if (r_pad_idx != '0) w_state_nxt = ST_FETCH;
                    else                      w_state_nxt = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI:  if (w_phase_last) w_state_nxt = ST_LOAD_LO;
            ST_LOAD_LO:  if (w_phase_last) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (r_state == ST_LATCH) begin
            w_shift_nxt = cfg_rd_data;
        end else if (r_state == ST_SHIFT_HI && w_phase_last) begin
            w_shift_nxt = r_shift << 1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are registered from the next state so the chain sees clean edges.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_pad_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdo     <= 1'b0;
            r_load    <= 1'b0;
            r_sresetn <= 1'b0;
        end else begin
            r_sresetn <= 1'b1;
            r_shift   <= w_shift_nxt;
            r_phase   <= (w_state_nxt != r_state || r_state == ST_IDLE) ? 8'd0 : r_phase + 8'd1;
            if (r_state == ST_LATCH) begin
                r_bit_cnt <= BIT_TOP;
            end else if (r_state == ST_SHIFT_HI && w_phase_last) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_state_nxt == ST_FETCH) begin
                r_pad_idx <= (r_state == ST_IDLE) ? IDX_TOP : r_pad_idx - 1'b1;
            end
            // Data only moves when the serial clock enters its low phase.
            if (w_state_nxt == ST_SHIFT_LO && r_state != ST_SHIFT_LO) begin
                r_sdo <= w_shift_nxt[CFG_BITS-1];
            end
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (r_state == ST_LOAD_LO) && (w_state_nxt == ST_IDLE);
            r_sclk <= (w_state_nxt == ST_SHIFT_HI);
            r_load <= (w_state_nxt == ST_LOAD_HI);
        end
    end

    assign xfer_busy       = r_busy;
    assign xfer_done       = r_done;
    assign cfg_rd_idx      = r_pad_idx;
    assign serial_clock    = r_sclk;
    assign serial_data_out = r_sdo;
    assign serial_load     = r_load;
    assign serial_resetn   = r_sresetn;

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Bench for gpio_cfg_serializer: three instances (2x4 div1, 2x4 div3, 38x13 div2)
// each observed by a chain model that shifts on serial_clock rises.
`timescale 1ns/1ps
module tb_gpio_cfg_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         resetn_v [3];
    logic         start_v  [3];
    logic         clr_v    [3];
    logic [15:0]  tbl      [3][64];

    logic         busy_v [3];
    logic         done_v [3];
    logic         sclk_v [3];
    logic         sdo_v  [3];
    logic         load_v [3];
    logic         sres_v [3];
    int           idx_v          [3];
    int           edges_v        [3];
    int           busy_cyc_v     [3];
    int           load_cyc_v     [3];
    int           load_pulse_v   [3];
    int           done_cnt_v     [3];
    int           chg_hi_v       [3];
    int           edges_at_load_v[3];
    logic [511:0] cap_v          [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int NP = (g == 2) ? 38 : 2;
        localparam int CB = (g == 2) ? 13 : 4;
        localparam int CD = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam int IW = $clog2(NP);

        logic [IW-1:0] idx;
        logic [CB-1:0] rd_data = '0;
        logic busy, done, sclk, sdo, load, sres;
        int edges = 0, busy_cyc = 0, load_cyc = 0, load_pulses = 0;
        int done_cnt = 0, chg_hi = 0, edges_at_load = 0;
        logic p_sclk = 1'b0, p_sdo = 1'b0, p_load = 1'b0;
        logic [511:0] chain = '0;
        logic [511:0] cap = '0;

        gpio_cfg_serializer #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(CD)) u_dut (
            .clock          (clock),
            .resetn         (resetn_v[g]),
            .xfer_start     (start_v[g]),
            .xfer_busy      (busy),
            .xfer_done      (done),
            .cfg_rd_idx     (idx),
            .cfg_rd_data    (rd_data),
            .serial_clock   (sclk),
            .serial_data_out(sdo),
            .serial_load    (load),
            .serial_resetn  (sres)
        );

        // Table RAM with one cycle read latency.
        always @(posedge clock) rd_data <= tbl[g][idx][CB-1:0];

        always @(negedge clock) begin
            if (clr_v[g]) begin
                edges = 0; busy_cyc = 0; load_cyc = 0; load_pulses = 0;
                done_cnt = 0; chg_hi = 0; edges_at_load = 0; cap = '0;
            end else begin
                if (sclk && !p_sclk) begin
                    edges++;
                    chain = {chain[510:0], sdo};
                end
                if (busy) busy_cyc++;
                if (load) load_cyc++;
                if (load && !p_load) begin
                    load_pulses++;
                    cap = chain;
                    edges_at_load = edges;
                end
                if (done) done_cnt++;
                if (sclk && sdo != p_sdo) chg_hi++;
            end
            p_sclk = sclk;
            p_sdo  = sdo;
            p_load = load;
        end

        assign busy_v[g]          = busy;
        assign done_v[g]          = done;
        assign sclk_v[g]          = sclk;
        assign sdo_v[g]           = sdo;
        assign load_v[g]          = load;
        assign sres_v[g]          = sres;
        assign idx_v[g]           = int'(idx);
        assign edges_v[g]         = edges;
        assign busy_cyc_v[g]      = busy_cyc;
        assign load_cyc_v[g]      = load_cyc;
        assign load_pulse_v[g]    = load_pulses;
        assign done_cnt_v[g]      = done_cnt;
        assign chg_hi_v[g]        = chg_hi;
        assign edges_at_load_v[g] = edges_at_load;
        assign cap_v[g]           = cap;
    end

    typedef struct {
        int          g;
        logic [15:0] w1;
        logic [15:0] w0;
        int          exp_busy;
        int          exp_edges;
        logic [7:0]  exp_bits;
        int          exp_load_cyc;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int g);
        clr_v[g] = 1'b1;
        tick();
        clr_v[g] = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (done_v[g] !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("done_seen[%0d]", g), int'(done_v[g]), 1);
    endtask

    task automatic run_xfer(input int g);
        clear_mon(g);
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
        wait_done(g, 5000);
        tick();
        tick();
    endtask

    task automatic check_quiet(input int g, input string tag);
        logic [5:0] outs;
        outs = {busy_v[g], done_v[g], sclk_v[g], sdo_v[g], load_v[g], sres_v[g]};
        check($sformatf("%s_outs[%0d]", tag, g), int'(outs), 0);
        check($sformatf("%s_idx[%0d]", tag, g), idx_v[g], 0);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            resetn_v[g] = 1'b0;
            start_v[g]  = 1'b0;
            clr_v[g]    = 1'b0;
            for (int k = 0; k < 64; k++) tbl[g][k] = '0;
        end
        // Busy = NP*(2+2*CD*CB)+2*CD, edges = NP*CB; bits are idx1 word then idx0 word.
        vecs[0] = '{0, 16'hA, 16'h5, 22, 8, 8'hA5, 1};
        vecs[1] = '{0, 16'h3, 16'hC, 22, 8, 8'h3C, 1};
        vecs[2] = '{1, 16'hA, 16'h5, 58, 8, 8'hA5, 3};
        vecs[3] = '{1, 16'h6, 16'h9, 58, 8, 8'h69, 3};

        repeat (3) tick();
        for (int g = 0; g < 3; g++) check_quiet(g, "reset");
        for (int g = 0; g < 3; g++) resetn_v[g] = 1'b1;
        check("sres_before_edge", int'(sres_v[0]), 0);
        tick();
        for (int g = 0; g < 3; g++) check($sformatf("sres_after_edge[%0d]", g), int'(sres_v[g]), 1);

        for (int v = 0; v < 4; v++) begin
            int g;
            g = vecs[v].g;
            tbl[g][1] = vecs[v].w1;
            tbl[g][0] = vecs[v].w0;
            run_xfer(g);
            check($sformatf("v%0d_busy", v), busy_cyc_v[g], vecs[v].exp_busy);
            check($sformatf("v%0d_edges", v), edges_v[g], vecs[v].exp_edges);
            check($sformatf("v%0d_bits", v), int'(cap_v[g][7:0]), int'(vecs[v].exp_bits));
            check($sformatf("v%0d_load_pulses", v), load_pulse_v[g], 1);
            check($sformatf("v%0d_load_width", v), load_cyc_v[g], vecs[v].exp_load_cyc);
            check($sformatf("v%0d_edges_before_load", v), edges_at_load_v[g], vecs[v].exp_edges);
            check($sformatf("v%0d_done_pulses", v), done_cnt_v[g], 1);
            check($sformatf("v%0d_sdo_stable_hi", v), chg_hi_v[g], 0);
            check($sformatf("v%0d_idle_busy", v), int'(busy_v[g]), 0);
        end

        // Back-to-back: start held high through two completions.
        tbl[0][1] = 16'hA;
        tbl[0][0] = 16'h5;
        clear_mon(0);
        start_v[0] = 1'b1;
        wait_done(0, 200);
        tick();
        check("b2b_accept_on_done", int'(busy_v[0]), 1);
        wait_done(0, 200);
        start_v[0] = 1'b0;
        repeat (3) tick();
        check("b2b_edges", edges_v[0], 16);
        check("b2b_dones", done_cnt_v[0], 2);
        check("b2b_loads", load_pulse_v[0], 2);
        check("b2b_busy", busy_cyc_v[0], 44);
        check("b2b_final_idle", int'(busy_v[0]), 0);

        // Start pulsed mid-shift is ignored.
        begin
            int n = 0;
            clear_mon(1);
            start_v[1] = 1'b1;
            tick();
            start_v[1] = 1'b0;
            while (edges_v[1] < 5 && n < 500) begin tick(); n++; end
            check("midstart_reach_edge5", edges_v[1], 5);
            start_v[1] = 1'b1;
            tick();
            start_v[1] = 1'b0;
            wait_done(1, 500);
            repeat (3) tick();
            check("midstart_busy", busy_cyc_v[1], 58);
            check("midstart_edges", edges_v[1], 8);
            check("midstart_bits", int'(cap_v[1][7:0]), 8'h69);
            check("midstart_dones", done_cnt_v[1], 1);
        end

        // Reset after the third rising edge aborts without a load.
        begin
            int n = 0;
            clear_mon(0);
            start_v[0] = 1'b1;
            tick();
            start_v[0] = 1'b0;
            while (edges_v[0] < 3 && n < 200) begin tick(); n++; end
            check("rst_reach_edge3", edges_v[0], 3);
            resetn_v[0] = 1'b0;
            #1;
            check_quiet(0, "midreset");
            repeat (3) tick();
            check("midreset_no_load", load_pulse_v[0], 0);
            check("midreset_no_done", done_cnt_v[0], 0);
            resetn_v[0] = 1'b1;
            check("midreset_sres_low", int'(sres_v[0]), 0);
            tick();
            check("midreset_sres_high", int'(sres_v[0]), 1);
            run_xfer(0);
            check("postrst_edges", edges_v[0], 8);
            check("postrst_busy", busy_cyc_v[0], 22);
            check("postrst_bits", int'(cap_v[0][7:0]), 8'hA5);
            check("postrst_loads", load_pulse_v[0], 1);
        end

        // Full-size chain with random tables.
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 38; k++) tbl[2][k] = 16'($urandom_range(0, 8191));
            run_xfer(2);
            check($sformatf("full%0d_edges", rep), edges_v[2], 38 * 13);
            check($sformatf("full%0d_busy", rep), busy_cyc_v[2], 38 * (2 + 2 * 2 * 13) + 2 * 2);
            check($sformatf("full%0d_loads", rep), load_pulse_v[2], 1);
            check($sformatf("full%0d_load_width", rep), load_cyc_v[2], 2);
            check($sformatf("full%0d_edges_before_load", rep), edges_at_load_v[2], 38 * 13);
            check($sformatf("full%0d_sdo_stable_hi", rep), chg_hi_v[2], 0);
            for (int k = 0; k < 38; k++) begin
                logic [511:0] sh;
                logic [15:0]  want;
                sh   = cap_v[2] >> (k * 13);
                want = tbl[2][k];
                check($sformatf("full%0d_pad%0d", rep, k), int'(sh[12:0]), int'(want[12:0]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
